// File: rtl/gray_wptr_full.sv
// Write-side pointer and full/level logic for an asynchronous FIFO.
// Keeps the binary/Gray write pointer and synchronises the foreign read pointer.
module gray_wptr_full #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_gray_async,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_gray,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;

  // Full means the pointers differ only in the wrap bit: in Gray code that
  // is the top two bits inverted and the rest equal.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rq_gray;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          push;

  assign push         = wr_en & ~full;
  assign wr_bin_next  = wr_bin + PW'(push);
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
  assign rq_gray      = sync_q[SYNC_STAGES-1];
  assign wr_addr      = wr_bin[ADDR_W-1:0];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin   <= '0;
      wr_gray  <= '0;
      full     <= 1'b0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_bin   <= wr_bin_next;
      wr_gray  <= wr_gray_next;
      full     <= (wr_gray_next == (rq_gray ^ FULL_MASK));
      level    <= wr_bin_next - rq_bin;
      overflow <= wr_en & full;
    end
  end

endmodule

// File: tb/tb_gray_wptr_full.sv
// Bench for gray_wptr_full: directed scenarios plus randomized traffic
// compared against an occupancy-arithmetic model with a delayed read view.
module tb_gray_wptr_full;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int PW    = AW + 1;
  localparam int MOD   = 1 << PW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] rd_gray_async;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_gray;
  logic          full;
  logic [PW-1:0] level;
  logic          overflow;

  gray_wptr_full #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_gray_async(rd_gray_async),
    .wr_addr      (wr_addr),
    .wr_gray      (wr_gray),
    .full         (full),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: write count, the read pointer as the write side currently sees it
  // (delayed SS cycles through a queue), and the resulting occupancy.
  int m_wr;
  int m_level;
  bit m_full;
  bit m_ovf;
  int rd_ptr;
  int hist[$];

  function automatic logic [PW-1:0] g(input int b);
    int v;
    v = b & (MOD - 1);
    return PW'(v ^ (v >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " wr_gray"},  32'(wr_gray),  32'(g(m_wr)));
    chk({ph, " wr_addr"},  32'(wr_addr),  32'(m_wr % DEPTH));
    chk({ph, " full"},     32'(full),     32'(m_full));
    chk({ph, " level"},    32'(level),    32'(m_level));
    chk({ph, " overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_zero(input string ph);
    chk({ph, " wr_gray"},  32'(wr_gray),  32'd0);
    chk({ph, " wr_addr"},  32'(wr_addr),  32'd0);
    chk({ph, " full"},     32'(full),     32'd0);
    chk({ph, " level"},    32'(level),    32'd0);
    chk({ph, " overflow"}, 32'(overflow), 32'd0);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input bit we, input int rdb, input string ph);
    int rq;
    bit pushed;
    wr_en         = we;
    rd_gray_async = g(rdb);
    @(posedge clk);
    rq = hist.pop_front();
    hist.push_back(rdb & (MOD - 1));
    pushed  = we && !m_full;
    m_ovf   = we && m_full;
    m_wr    = (m_wr + int'(pushed)) & (MOD - 1);
    m_level = (m_wr - rq) & (MOD - 1);
    m_full  = (m_level == DEPTH);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    #2;
    rst_n         = 1'b0;
    wr_en         = 1'b1;
    rd_gray_async = 5'b10101;
    #1;
    check_zero({ph, " async"});
    repeat (3) @(posedge clk);
    #1;
    check_zero({ph, " held"});
    @(negedge clk);
    rst_n         = 1'b1;
    wr_en         = 1'b0;
    rd_gray_async = '0;
    m_wr    = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    rd_ptr  = 0;
    hist    = '{0, 0};
  endtask

  initial begin
    logic [PW-1:0] fill_gray [4];
    int r;
    bit we;
    fill_gray = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};

    rst_n         = 1'b1;
    wr_en         = 1'b0;
    rd_gray_async = '0;

    do_reset("reset");

    // Fill to full; first push lands on the first edge after release.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 0, "fill");
      if (i < 4) chk("fill gray seq", 32'(wr_gray), 32'(fill_gray[i]));
    end
    chk("full gray",  32'(wr_gray), 32'(5'b11000));
    chk("full addr",  32'(wr_addr), 32'd0);
    chk("full level", 32'(level),   32'd16);
    chk("full flag",  32'(full),    32'd1);

    // Rejected writes.
    step(1'b1, 0, "ovf");
    chk("ovf pulse", 32'(overflow), 32'd1);
    chk("ovf gray",  32'(wr_gray),  32'(5'b11000));
    chk("ovf level", 32'(level),    32'd16);
    step(1'b1, 0, "ovf2");
    chk("ovf consecutive", 32'(overflow), 32'd1);
    step(1'b0, 0, "ovf end");
    chk("ovf clear", 32'(overflow), 32'd0);

    // Read pointer moves to 3: seen on the third edge only.
    rd_ptr = 3;
    step(1'b0, rd_ptr, "drain");
    chk("drain e1 full", 32'(full), 32'd1);
    step(1'b0, rd_ptr, "drain");
    chk("drain e2 level", 32'(level), 32'd16);
    step(1'b0, rd_ptr, "drain");
    chk("drain e3 full",  32'(full),  32'd0);
    chk("drain e3 level", 32'(level), 32'd13);
    step(1'b1, rd_ptr, "drain push");
    chk("drain push level", 32'(level), 32'd14);

    // Wrap: reader trails the writer by two.
    rd_ptr = (m_wr - 2) & (MOD - 1);
    repeat (3) step(1'b0, rd_ptr, "wrap settle");
    for (int i = 0; i < 40; i++) begin
      int prev;
      prev   = m_wr;
      rd_ptr = (m_wr - 2) & (MOD - 1);
      if (prev == MOD - 1) chk("pre-wrap gray", 32'(wr_gray), 32'(5'b10000));
      step(1'b1, rd_ptr, "wrap");
      if (prev == MOD - 1) chk("wrap gray", 32'(wr_gray), 32'd0);
      chk("wrap no full", 32'(full),     32'd0);
      chk("wrap no ovf",  32'(overflow), 32'd0);
    end
    rd_ptr = (m_wr - 2) & (MOD - 1);
    repeat (3) step(1'b0, rd_ptr, "wrap idle");
    chk("wrap level", 32'(level), 32'd2);

    // Push and read update in the same cycle at level 15.
    r = rd_ptr;
    repeat (13) step(1'b1, r, "sim fill");
    chk("sim level15", 32'(level), 32'd15);
    r = (r + 1) & (MOD - 1);
    step(1'b1, r, "sim");
    chk("sim e1 level", 32'(level), 32'd16);
    chk("sim e1 full",  32'(full),  32'd1);
    step(1'b0, r, "sim");
    chk("sim e2 full", 32'(full), 32'd1);
    step(1'b0, r, "sim");
    chk("sim e3 level", 32'(level), 32'd15);
    chk("sim e3 full",  32'(full),  32'd0);
    rd_ptr = r;

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("mid reset");
      we = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) < 45 && ((m_wr - rd_ptr) & (MOD - 1)) > 0)
        rd_ptr = (rd_ptr + 1) & (MOD - 1);
      step(we, rd_ptr, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gray_wptr_full.md
GRAY_WPTR_FULL -- requirements
Module: gray_wptr_full

Interface
REQ-001 Parameter ADDR_W, default 4: FIFO address width; depth = 2^ADDR_W; legal range >= 1.
REQ-002 Parameter SYNC_STAGES, default 2: flops in the read-pointer synchroniser; legal range >= 2.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  input  1  write request for the current cycle.
REQ-006 rd_gray_async  input  ADDR_W+1  read pointer in Gray code, from a foreign clock domain.
REQ-007 wr_addr  output  ADDR_W  RAM write address.
REQ-008 wr_gray  output  ADDR_W+1  write pointer in Gray code, registered, for export to the read domain.
REQ-009 full  output  1  FIFO full, registered.
REQ-010 level  output  ADDR_W+1  fill level as seen from the write side, 0..2^ADDR_W, registered.
REQ-011 overflow  output  1  one-cycle pulse on a rejected write.

Function
REQ-012 The block SHALL hold an ADDR_W+1-bit binary write pointer wr_bin; push = wr_en & ~full; wr_bin_next = wr_bin + push, modulo 2^(ADDR_W+1).
REQ-013 wr_bin SHALL load wr_bin_next every rising clk edge.
REQ-014 wr_gray SHALL load wr_bin_next ^ (wr_bin_next >> 1) on the same edge, so that wr_gray == gray(wr_bin) always holds and changes by exactly one bit per push.
REQ-015 wr_addr SHALL equal wr_bin[ADDR_W-1:0], driven directly from the register with no combinational path from wr_en.
REQ-016 rd_gray_async SHALL pass through a chain of SYNC_STAGES flops; rq_gray is the last stage; no other logic reads rd_gray_async.
REQ-017 rq_bin SHALL be the Gray-to-binary conversion of rq_gray, generic in width: bit i = XOR of rq_gray[ADDR_W:i].
REQ-018 full SHALL load (gray(wr_bin_next) == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}) each edge; for ADDR_W=1 the lower field is empty.
REQ-019 level SHALL load (wr_bin_next - rq_bin) modulo 2^(ADDR_W+1) each edge.
REQ-020 overflow SHALL load wr_en & full each edge: a 1-cycle pulse per rejected write, staying high on consecutive rejected cycles.
REQ-021 A write while full SHALL leave wr_bin, wr_gray, wr_addr and level unchanged.
REQ-022 Write-side effect latency: a push is visible in wr_gray, full and level one edge after the sampling edge.
REQ-023 Read-side effect latency: a change on rd_gray_async is reflected in full and level after SYNC_STAGES+1 edges.
REQ-024 Wrap-around: wr_bin SHALL roll from 2^(ADDR_W+1)-1 to 0 with no special handling; level and full remain correct across the wrap.
REQ-025 A push and a read-pointer update in the same cycle SHALL both take effect; level reflects the push immediately and the read after REQ-023 latency.

Reset
REQ-026 rst_n low SHALL immediately clear wr_bin, wr_gray, wr_addr, every synchroniser stage, full, level and overflow to 0, independent of clk.
REQ-027 While rst_n is low, wr_en SHALL be ignored.
REQ-028 After rst_n deasserts, the first push is accepted on the first rising edge at which rst_n is high.
REQ-029 Reset mid-operation SHALL discard all pointer state with no recovery of the prior level.

Verification (ADDR_W=4, SYNC_STAGES=2)
REQ-030 Reset: rst_n=0 with wr_en=1 and rd_gray_async=5'b10101 -> all outputs 0 asynchronously, held at 0 while rst_n is low.
REQ-031 Fill: rd_gray_async=0, 16 consecutive pushes.
- wr_gray follows 00000,00001,00011,00010,00110,...
- After the 16th push: wr_gray=5'b11000, wr_addr=0, level=16, full=1.
REQ-032 Overflow: 17th wr_en while full -> overflow=1 for exactly one cycle; wr_gray stays 11000; level stays 16.
REQ-033 Drain sync: from full, set rd_gray_async=5'b00010 (binary 3).
- full=0 and level=13 appear on the 3rd edge, not earlier.
- The next push then gives level=14.
REQ-034 Wrap: 40 pushes with rd_gray_async tracking gray(wr_bin-2).
- wr_gray steps 10000 -> 00000 at the wrap.
- full never asserts and overflow never pulses.
- level settles at 2 after the sync latency.
REQ-035 Simultaneous: push and rd_gray_async change in the same cycle at level 15 -> level=16 and full=1 next edge, then level=15 and full=0 three edges after the read change (rd pointer +1).
